// File: rtl/lcd_hd44780_ctrl.sv
// lcd_hd44780_ctrl
//   HD44780 character-LCD controller for the 4-bit bus. After reset it waits
//   for LCD power-up and runs the init sequence: three 0x3 nibbles, a 0x2
//   nibble, then the function-set, entry-mode, display-control and clear
//   bytes. After that it accepts command/data bytes over a valid/ready
//   handshake. Each byte goes out as two nibbles, each with an E strobe, and
//   is followed by a busy wait whose length depends on the command.
//
// Ports
//   Clock                   system clock, all logic on the rising edge
//   Reset                   synchronous, active-low reset
//   iData[7:0]              byte to write
//   iRS                     register select for iData (0 command, 1 data)
//   iValid                  request; a transfer happens when iValid && oReady
//   oReady                  idle and able to accept a byte
//   oInitDone               init sequence finished; held until reset
//   oLCD_Enabled            LCD E strobe
//   oLCD_RegisterSelect     LCD RS
//   oLCD_ReadWrite          LCD R/W, always write
//   oLCD_StrataFlashControl StrataFlash chip enable, always high (disabled)
//   oLCD_Data[3:0]          LCD DB[7:4]

module lcd_hd44780_ctrl #(
   parameter int unsigned T_POWERUP    = 750000,
   parameter int unsigned T_INIT1      = 205000,
   parameter int unsigned T_INIT2      = 5000,
   parameter int unsigned T_SETUP      = 2,
   parameter int unsigned T_EN_HIGH    = 12,
   parameter int unsigned T_NIBBLE_GAP = 50,
   parameter int unsigned T_CMD        = 2000,
   parameter int unsigned T_CLEAR      = 82000,
   parameter logic [7:0]  FUNC_SET     = 8'h28,
   parameter logic [7:0]  ENTRY_MODE   = 8'h06,
   parameter logic [7:0]  DISP_CTRL    = 8'h0C
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] iData,
   input  logic       iRS,
   input  logic       iValid,
   output logic       oReady,
   output logic       oInitDone,
   output logic       oLCD_Enabled,
   output logic       oLCD_RegisterSelect,
   output logic       oLCD_ReadWrite,
   output logic       oLCD_StrataFlashControl,
   output logic [3:0] oLCD_Data
);

   // Init nibbles are carried in the upper half of byte_q so that the
   // shared nibble path always sends byte_q[7:4] first.
   localparam logic [7:0] InitNib3  = 8'h30;
   localparam logic [7:0] InitNib2  = 8'h20;
   localparam logic [7:0] ClearCmd  = 8'h01;
   localparam logic [2:0] LastNib   = 3'd3;
   localparam logic [2:0] FirstByte = 3'd4;
   localparam logic [2:0] LastByte  = 3'd7;

   typedef enum logic [3:0] {
      StPwrWait,
      StInitNib,
      StInitWait,
      StIdle,
      StSetup,
      StEnHi,
      StHold,
      StNibbleGap,
      StPostWait
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   // Index of the current init item: 0..3 single nibbles, 4..7 bytes.
   logic [2:0]  step_q, step_d;
   logic [7:0]  byte_q, byte_d;
   logic        rs_q, rs_d;
   logic        lower_q, lower_d;
   // Set while sending a lone init nibble (no lower half, no post-wait).
   logic        single_q, single_d;
   logic        init_done_q, init_done_d;

   logic        e_q;
   logic        rs_out_q;
   logic [3:0]  data_q;

   logic [31:0] wait_len;
   logic        expired;
   logic        long_wait;
   logic [2:0]  step_inc;
   logic [7:0]  next_init_byte;
   logic        drive_bus;
   logic [3:0]  cur_nib;

   // Clear (0x01) and return-home (0x02/0x03) need the long busy wait.
   assign long_wait = !rs_q && (byte_q[7:2] == 6'd0) && (byte_q != 8'd0);

   always_comb begin
      wait_len = 32'd1;
      case (state_q)
         StPwrWait:   wait_len = T_POWERUP;
         StInitNib:   wait_len = T_SETUP;
         StSetup:     wait_len = T_SETUP;
         StEnHi:      wait_len = T_EN_HIGH;
         StHold:      wait_len = 32'd1;
         StNibbleGap: wait_len = T_NIBBLE_GAP;
         StInitWait: begin
            case (step_q)
               3'd0:    wait_len = T_INIT1;
               3'd1:    wait_len = T_INIT2;
               3'd2:    wait_len = T_INIT2;
               default: wait_len = T_CMD;
            endcase
         end
         StPostWait:  wait_len = long_wait ? T_CLEAR : T_CMD;
         default:     wait_len = 32'd1;
      endcase
   end

   // A wait of N cycles ends on the cycle the counter reads N-1.
   assign expired = (cnt_q == wait_len - 32'd1);

   always_comb begin
      step_inc = step_q + 3'd1;
      case (step_inc)
         3'd5:    next_init_byte = ENTRY_MODE;
         3'd6:    next_init_byte = DISP_CTRL;
         3'd7:    next_init_byte = ClearCmd;
         default: next_init_byte = FUNC_SET;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      byte_d      = byte_q;
      rs_d        = rs_q;
      lower_d     = lower_q;
      single_d    = single_q;
      init_done_d = init_done_q;

      case (state_q)
         StPwrWait: begin
            if (expired) begin
               state_d  = StInitNib;
               step_d   = 3'd0;
               byte_d   = InitNib3;
               rs_d     = 1'b0;
               lower_d  = 1'b0;
               single_d = 1'b1;
            end
         end
         StInitNib: begin
            if (expired) begin
               state_d = StEnHi;
            end
         end
         StInitWait: begin
            if (expired) begin
               step_d = step_inc;
               if (step_q == LastNib) begin
                  state_d  = StSetup;
                  byte_d   = FUNC_SET;
                  lower_d  = 1'b0;
                  single_d = 1'b0;
               end else begin
                  state_d = StInitNib;
                  byte_d  = (step_inc == LastNib) ? InitNib2 : InitNib3;
               end
            end
         end
         StIdle: begin
            if (iValid) begin
               state_d  = StSetup;
               byte_d   = iData;
               rs_d     = iRS;
               lower_d  = 1'b0;
               single_d = 1'b0;
            end
         end
         StSetup: begin
            if (expired) begin
               state_d = StEnHi;
            end
         end
         StEnHi: begin
            if (expired) begin
               state_d = StHold;
            end
         end
         StHold: begin
            if (single_q) begin
               state_d = StInitWait;
            end else if (!lower_q) begin
               state_d = StNibbleGap;
               lower_d = 1'b1;
            end else begin
               state_d = StPostWait;
            end
         end
         StNibbleGap: begin
            if (expired) begin
               state_d = StSetup;
            end
         end
         StPostWait: begin
            if (expired) begin
               if (init_done_q) begin
                  state_d = StIdle;
               end else if (step_q == LastByte) begin
                  state_d     = StIdle;
                  init_done_d = 1'b1;
               end else begin
                  state_d = StSetup;
                  step_d  = step_inc;
                  byte_d  = next_init_byte;
                  lower_d = 1'b0;
               end
            end
         end
         default: begin
            state_d     = StPwrWait;
            step_d      = 3'd0;
            init_done_d = 1'b0;
         end
      endcase

      cnt_d = (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
   end

   // Bus is driven only from setup through hold; zero in every wait/idle state.
   assign drive_bus = (state_q == StInitNib) || (state_q == StSetup) ||
                      (state_q == StEnHi) || (state_q == StHold);
   assign cur_nib   = lower_q ? byte_q[3:0] : byte_q[7:4];

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q     <= StPwrWait;
         cnt_q       <= 32'd0;
         step_q      <= 3'd0;
         byte_q      <= 8'd0;
         rs_q        <= 1'b0;
         lower_q     <= 1'b0;
         single_q    <= 1'b0;
         init_done_q <= 1'b0;
         e_q         <= 1'b0;
         rs_out_q    <= 1'b0;
         data_q      <= 4'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         step_q      <= step_d;
         byte_q      <= byte_d;
         rs_q        <= rs_d;
         lower_q     <= lower_d;
         single_q    <= single_d;
         init_done_q <= init_done_d;
         // Pin registers follow the state one cycle later, all in lockstep,
         // so data/RS bracket E exactly as the state sequence does.
         e_q         <= (state_q == StEnHi);
         rs_out_q    <= drive_bus ? rs_q : 1'b0;
         data_q      <= drive_bus ? cur_nib : 4'd0;
      end
   end

   assign oReady                  = (state_q == StIdle);
   assign oInitDone               = init_done_q;
   assign oLCD_Enabled            = e_q;
   assign oLCD_RegisterSelect     = rs_out_q;
   assign oLCD_ReadWrite          = 1'b0;
   assign oLCD_StrataFlashControl = 1'b1;
   assign oLCD_Data               = data_q;

   // FirstByte documents where the byte steps start; kept for readability.
   logic unused_first_byte;
   assign unused_first_byte = ^FirstByte;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Testbench for lcd_hd44780_ctrl with shortened timing. Observed E pulses are
// logged (nibble, RS, rise cycle, width, setup/hold stability) and compared
// with a pulse list predicted from the timing rules of the controller.

module tb_lcd_hd44780_ctrl;

   localparam int unsigned TP  = 20;
   localparam int unsigned TI1 = 8;
   localparam int unsigned TI2 = 4;
   localparam int unsigned TS  = 2;
   localparam int unsigned TE  = 3;
   localparam int unsigned TG  = 5;
   localparam int unsigned TC  = 10;
   localparam int unsigned TCL = 30;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic [7:0] iData = 8'd0;
   logic       iRS = 1'b0;
   logic       iValid = 1'b0;
   logic       oReady;
   logic       oInitDone;
   logic       oLCD_Enabled;
   logic       oLCD_RegisterSelect;
   logic       oLCD_ReadWrite;
   logic       oLCD_StrataFlashControl;
   logic [3:0] oLCD_Data;

   lcd_hd44780_ctrl #(
      .T_POWERUP   (TP),
      .T_INIT1     (TI1),
      .T_INIT2     (TI2),
      .T_SETUP     (TS),
      .T_EN_HIGH   (TE),
      .T_NIBBLE_GAP(TG),
      .T_CMD       (TC),
      .T_CLEAR     (TCL),
      .FUNC_SET    (8'h28),
      .ENTRY_MODE  (8'h06),
      .DISP_CTRL   (8'h0C)
   ) u_dut (
      .Clock                  (Clock),
      .Reset                  (Reset),
      .iData                  (iData),
      .iRS                    (iRS),
      .iValid                 (iValid),
      .oReady                 (oReady),
      .oInitDone              (oInitDone),
      .oLCD_Enabled           (oLCD_Enabled),
      .oLCD_RegisterSelect    (oLCD_RegisterSelect),
      .oLCD_ReadWrite         (oLCD_ReadWrite),
      .oLCD_StrataFlashControl(oLCD_StrataFlashControl),
      .oLCD_Data              (oLCD_Data)
   );

   always #5 Clock = ~Clock;

   // cyc holds the number of the most recent rising edge.
   int unsigned cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   typedef struct {
      logic [3:0]  nib;
      logic        rs;
      int unsigned rise;
   } exp_t;

   typedef struct {
      logic [3:0]  nib;
      logic        rs;
      int unsigned rise;
      int unsigned width;
      bit          stable;
      bit          setup_ok;
      bit          hold_ok;
   } obs_t;

   exp_t exp_q[$];
   obs_t obs_q[$];

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned free_cyc = 32'hFFFF_FFFF;
   int unsigned done_cyc = 32'hFFFF_FFFF;

   logic [3:0] init_nib [4] = '{4'h3, 4'h3, 4'h3, 4'h2};
   int unsigned init_wait [4] = '{TI1, TI2, TI2, TC};
   logic [7:0] init_byte [4] = '{8'h28, 8'h06, 8'h0C, 8'h01};

   // Pulse monitor state.
   bit          prev_e = 1'b0;
   obs_t        cur;
   logic [5:0]  hist [4];
   int unsigned nvalid = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int unsigned post_len(input logic [7:0] b, input logic rs);
      if (!rs && b >= 8'd1 && b <= 8'd3) return TCL;
      return TC;
   endfunction

   task automatic sample();
      logic [5:0] now;
      now = {oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data};
      if (Reset !== 1'b1) begin
         prev_e = 1'b0;
         nvalid = 0;
         return;
      end
      if (now[5] && !prev_e) begin
         cur.nib      = now[3:0];
         cur.rs       = now[4];
         cur.rise     = cyc;
         cur.width    = 0;
         cur.stable   = 1'b1;
         cur.hold_ok  = 1'b0;
         cur.setup_ok = (nvalid >= TS);
         for (int j = 0; j < TS; j++) begin
            if (hist[j] !== {1'b0, now[4:0]}) cur.setup_ok = 1'b0;
         end
      end else if (now[5]) begin
         if (now[4:0] !== {cur.rs, cur.nib}) cur.stable = 1'b0;
      end else if (prev_e) begin
         cur.width   = cyc - cur.rise;
         cur.hold_ok = (now[4:0] === {cur.rs, cur.nib});
         obs_q.push_back(cur);
      end
      for (int j = 3; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = now;
      if (nvalid < 4) nvalid++;
      prev_e = now[5];
   endtask

   task automatic tick();
      sample();
      @(negedge Clock);
   endtask

   // Expected pulses and busy time for a byte accepted on edge a.
   task automatic accept(input logic [7:0] d, input logic rs);
      int unsigned a, r1, r2;
      a  = cyc + 1;
      r1 = a + TS + 1;
      r2 = r1 + TE + 1 + TG + TS;
      exp_q.push_back('{nib: d[7:4], rs: rs, rise: r1});
      exp_q.push_back('{nib: d[3:0], rs: rs, rise: r2});
      free_cyc = a + 2 * (TS + TE + 1) + TG + post_len(d, rs);
   endtask

   // One cycle: check handshake outputs against the model, then drive inputs.
   task automatic step(input logic v, input logic [7:0] d, input logic rs);
      bit mr, md;
      sample();
      mr = (cyc >= free_cyc);
      md = (cyc >= done_cyc);
      chk("ready", 32'(oReady), 32'(mr));
      chk("init_done", 32'(oInitDone), 32'(md));
      if (mr) begin
         chk("idle_data", 32'(oLCD_Data), 32'd0);
         chk("idle_rs", 32'(oLCD_RegisterSelect), 32'd0);
      end
      iValid = v;
      iData  = d;
      iRS    = rs;
      if (mr && v) accept(d, rs);
      @(negedge Clock);
   endtask

   // Called on the negedge where Reset is driven high.
   task automatic start_init();
      int unsigned r, last, w;
      r = cyc + 1 + TP + TS;
      last = r;
      w = 0;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back('{nib: init_nib[i], rs: 1'b0, rise: r});
         last = r;
         w = init_wait[i];
         r = r + TE + 1 + w + TS;
      end
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back('{nib: init_byte[i][7:4], rs: 1'b0, rise: r});
         r = r + TE + 1 + TG + TS;
         exp_q.push_back('{nib: init_byte[i][3:0], rs: 1'b0, rise: r});
         last = r;
         w = post_len(init_byte[i], 1'b0);
         r = r + TE + 1 + w + TS;
      end
      done_cyc = last + TE + w;
      free_cyc = done_cyc;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 300 && cyc < free_cyc; i++) step(1'b0, 8'($urandom), 1'b0);
   endtask

   task automatic check_pulses();
      exp_t e;
      obs_t o;
      chk("pulse_count", 32'(obs_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         chk("pulse_nib", 32'(o.nib), 32'(e.nib));
         chk("pulse_rs", 32'(o.rs), 32'(e.rs));
         chk("pulse_rise", o.rise, e.rise);
         chk("pulse_width", o.width, TE);
         chk("pulse_stable", 32'(o.stable), 32'd1);
         chk("pulse_setup", 32'(o.setup_ok), 32'd1);
         chk("pulse_hold", 32'(o.hold_ok), 32'd1);
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic send(input logic [7:0] d, input logic rs);
      wait_ready();
      step(1'b1, d, rs);
      wait_ready();
      check_pulses();
   endtask

   task automatic check_reset_outputs();
      chk("rst_e", 32'(oLCD_Enabled), 32'd0);
      chk("rst_rs", 32'(oLCD_RegisterSelect), 32'd0);
      chk("rst_data", 32'(oLCD_Data), 32'd0);
      chk("rst_ready", 32'(oReady), 32'd0);
      chk("rst_init_done", 32'(oInitDone), 32'd0);
   endtask

   task automatic run_init();
      Reset = 1'b1;
      start_init();
      // iValid held high with changing data: nothing may be taken before init ends.
      for (int i = 0; i < 800 && cyc <= done_cyc + 2; i++) begin
         step(1'b1, 8'($urandom), 1'($urandom));
      end
      wait_ready();
      check_pulses();
   endtask

   initial begin
      int unsigned a;

      repeat (3) @(negedge Clock);
      check_reset_outputs();
      chk("rst_rw", 32'(oLCD_ReadWrite), 32'd0);
      chk("rst_sf", 32'(oLCD_StrataFlashControl), 32'd1);

      run_init();

      send(8'h41, 1'b1);
      send(8'h01, 1'b0);
      send(8'h80, 1'b0);
      send(8'h03, 1'b0);
      send(8'h04, 1'b0);
      send(8'h00, 1'b0);
      send(8'h02, 1'b1);
      send(8'h02, 1'b0);

      // Continuous valid with changing data.
      for (int i = 0; i < 400; i++) step(1'b1, 8'($urandom), 1'($urandom));
      wait_ready();
      check_pulses();

      // Sparse valid, including bytes in the clear/home range.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 7)), 1'($urandom));
      end
      wait_ready();
      check_pulses();

      // Reset in the middle of the upper-nibble E pulse of a data byte.
      wait_ready();
      a = cyc + 1;
      step(1'b1, 8'h41, 1'b1);
      while (cyc < a + 4) step(1'b0, 8'h00, 1'b0);
      chk("mid_e", 32'(oLCD_Enabled), 32'd1);
      Reset = 1'b0;
      iValid = 1'b0;
      exp_q.delete();
      free_cyc = 32'hFFFF_FFFF;
      done_cyc = 32'hFFFF_FFFF;
      tick();
      check_reset_outputs();
      obs_q.delete();
      tick();

      run_init();
      send(8'h4C, 1'b1);
      chk("end_rw", 32'(oLCD_ReadWrite), 32'd0);
      chk("end_sf", 32'(oLCD_StrataFlashControl), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/lcd_hd44780_ctrl.md
Name: lcd_hd44780_ctrl

Overview:
- Parametrised next-generation HD44780 character-LCD controller driving the 4-bit interface.
- Runs the full power-on init sequence with configurable timing and configuration bytes.
- Then accepts command/data bytes through a valid/ready handshake and generates correct E pulses and per-command busy waits.
- Sits between application logic (text writer) and the LCD pins.

Parameters:
- T_POWERUP, 750000, cycles waited after reset before the first init nibble (15 ms at 50 MHz)
- T_INIT1, 205000, wait after first 0x3 nibble (4.1 ms)
- T_INIT2, 5000, wait after second and third 0x3 nibbles (100 us)
- T_SETUP, 2, cycles data/RS stable with E low before E rises
- T_EN_HIGH, 12, cycles E held high per nibble
- T_NIBBLE_GAP, 50, cycles between upper-nibble end and lower-nibble start
- T_CMD, 2000, post-byte wait for normal commands/data (40 us)
- T_CLEAR, 82000, post-byte wait for clear (0x01) and home (0x02/0x03) commands (1.64 ms)
- FUNC_SET, 8'h28, function-set byte sent during init
- ENTRY_MODE, 8'h06, entry-mode byte sent during init
- DISP_CTRL, 8'h0C, display-control byte sent during init

Ports:
- Clock  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-low reset
- iData  in  8  byte to write
- iRS  in  1  register select for iData: 0 = command, 1 = data
- iValid  in  1  request; transfer occurs when iValid && oReady
- oReady  out  1  controller idle and able to accept a byte
- oInitDone  out  1  init sequence complete; stays 1 until reset
- oLCD_Enabled  out  1  LCD E strobe
- oLCD_RegisterSelect  out  1  LCD RS
- oLCD_ReadWrite  out  1  tied 0 (write only)
- oLCD_StrataFlashControl  out  1  tied 1
- oLCD_Data  out  4  LCD DB[7:4]

Behaviour:
- Reset (Reset==0 at an edge):
  - State becomes PWR_WAIT; counter cleared.
  - Outputs: oLCD_Enabled=0, oLCD_RegisterSelect=0, oLCD_Data=0, oReady=0, oInitDone=0.
  - Reset asserted mid-operation aborts immediately with the same values; no partial E pulse survives.
- Single 32-bit cycle counter, cleared on every state entry. A wait of N cycles means the state is exited on the cycle the counter reaches N-1.
- Nibble write sub-sequence (shared by init and run):
  - SETUP: T_SETUP cycles, E=0, data/RS driven.
  - EN_HI: T_EN_HIGH cycles, E=1.
  - HOLD: 1 cycle, E=0, data/RS unchanged.
- Byte write:
  - Upper nibble, then NIBBLE_GAP (T_NIBBLE_GAP cycles, E=0), then lower nibble, then POST_WAIT.
  - POST_WAIT lasts T_CLEAR if RS==0 and byte[7:2]==0 with byte!=0; otherwise T_CMD.
- Init sequence, RS=0 throughout:
  - PWR_WAIT (T_POWERUP).
  - Nibble 0x3, wait T_INIT1.
  - Nibble 0x3, wait T_INIT2.
  - Nibble 0x3, wait T_INIT2.
  - Nibble 0x2, wait T_CMD.
  - Bytes FUNC_SET, ENTRY_MODE, DISP_CTRL, 0x01, each via byte write with its post-wait.
- An init step index register selects the next item; it advances only on wait expiry.
- oLCD_Data and oLCD_RegisterSelect are registered outputs, driven to 0 in every wait and idle state.
- On completion: oInitDone=1, IDLE state, oReady=1.
- Handshake:
  - In IDLE, iValid=1 latches iData and iRS into internal registers on that edge.
  - oReady goes 0 the next cycle; SETUP of the upper nibble starts the next cycle.
  - iValid is ignored while oReady=0, including during init; no queuing.
- oReady returns to 1 on the cycle after POST_WAIT expires.
- Latency from accept edge to first E rise: T_SETUP+1 cycles.
- Byte occupancy: 2*(T_SETUP+T_EN_HIGH+1)+T_NIBBLE_GAP+post-wait cycles.
- Parameters of 0 are illegal; behaviour is unspecified.
- States: PWR_WAIT, INIT_NIB, INIT_WAIT, IDLE, SETUP, EN_HI, HOLD, NIBBLE_GAP, POST_WAIT. An illegal encoding returns to PWR_WAIT.

Test Plan:
Simulation uses T_POWERUP=20, T_INIT1=8, T_INIT2=4, T_SETUP=2, T_EN_HIGH=3, T_NIBBLE_GAP=5, T_CMD=10, T_CLEAR=30.
- Release Reset, idle inputs -> E pulse sequence on oLCD_Data: 3,3,3,2 then 2,8,0,6,0,C,0,1. Every pulse is exactly 3 cycles wide with RS=0. The first E rise is exactly 22 cycles after release. oInitDone=1 after the final 30-cycle wait.
- After init, send iData=8'h41, iRS=1 -> oReady drops next cycle. Pulses carry nibble 4 then 1 with RS=1. Exactly 5 E-low cycles between the nibbles (plus setup/hold). oReady=1 again 10 cycles after the second HOLD.
- Send command 8'h01, iRS=0, then command 8'h80 -> post-wait of 30 cycles after 0x01 and 10 cycles after 0x80.
- Hold iValid=1 continuously with changing iData -> bytes written equal exactly the values present on the accept edges. No byte is accepted during init or while busy.
- Assert Reset low during EN_HI of a data byte -> next cycle E=0, oReady=0, oInitDone=0. After release, the full init sequence restarts from PWR_WAIT.
- Data and RS are checked stable from SETUP start through HOLD end on every nibble, and E is never high in any wait state.
